// File: rtl/tia_write_address_decodes.sv
// TIA write-register address decoder: 6-bit CPU write address to 45 one-hot strobes.
// Optional TIA_WDEC_UNMAPPED_FLAG_EN adds an undef strobe for writes to 0x2D..0x3F.
module tia_write_address_decodes (
    input  logic       phi2,
    input  logic       reset,
    input  logic [5:0] a,
    input  logic       w_bar,
    output logic       vsyn,
    output logic       vblk,
    output logic       wsyn,
    output logic       rsyn,
    output logic       nsz0,
    output logic       nsz1,
    output logic       p0ci,
    output logic       p1ci,
    output logic       pfci,
    output logic       bkci,
    output logic       pfct,
    output logic       p0rf,
    output logic       p1rf,
    output logic       pf0,
    output logic       pf1,
    output logic       pf2,
    output logic       p0re,
    output logic       p1re,
    output logic       m0re,
    output logic       m1re,
    output logic       blre,
    output logic       auc0,
    output logic       auc1,
    output logic       auf0,
    output logic       auf1,
    output logic       auv0,
    output logic       auv1,
    output logic       p0cr,
    output logic       p1cr,
    output logic       m0en,
    output logic       m1en,
    output logic       blen,
    output logic       p0hm,
    output logic       p1hm,
    output logic       m0hm,
    output logic       m1hm,
    output logic       blhm,
    output logic       p0vd,
    output logic       p1vd,
    output logic       blvd,
    output logic       m0pre,
    output logic       m1pre,
    output logic       hmove,
    output logic       hmclr,
`ifdef TIA_WDEC_UNMAPPED_FLAG_EN
    output logic       cxclr,
    output logic       undef
`else
    output logic       cxclr
`endif
);

    localparam int unsigned NREG = 45;
    localparam logic [5:0] LAST = 6'h2C;

    logic            wr;
    logic            mapped;
    logic [NREG-1:0] dec;
    logic [NREG-1:0] strb_q;

    assign wr     = ~w_bar;
    assign mapped = (a <= LAST);

    // One-hot decode; nothing fires on reads or unmapped addresses.
    always_comb begin
        dec = '0;
        if (wr && mapped) begin
            for (int i = 0; i < NREG; i++) begin
                if (a == 6'(i)) begin
                    dec[i] = 1'b1;
                end
            end
        end
    end

    // Strobes update on the falling edge that ends the bus cycle.
    always_ff @(negedge phi2 or posedge reset) begin
        if (reset) begin
            strb_q <= '0;
        end else begin
            strb_q <= dec;
        end
    end

`ifdef TIA_WDEC_UNMAPPED_FLAG_EN
    logic undef_q;

    always_ff @(negedge phi2 or posedge reset) begin
        if (reset) begin
            undef_q <= 1'b0;
        end else begin
            undef_q <= wr & ~mapped;
        end
    end

    assign undef = undef_q;
`endif

    assign vsyn  = strb_q[0];
    assign vblk  = strb_q[1];
    assign wsyn  = strb_q[2];
    assign rsyn  = strb_q[3];
    assign nsz0  = strb_q[4];
    assign nsz1  = strb_q[5];
    assign p0ci  = strb_q[6];
    assign p1ci  = strb_q[7];
    assign pfci  = strb_q[8];
    assign bkci  = strb_q[9];
    assign pfct  = strb_q[10];
    assign p0rf  = strb_q[11];
    assign p1rf  = strb_q[12];
    assign pf0   = strb_q[13];
    assign pf1   = strb_q[14];
    assign pf2   = strb_q[15];
    assign p0re  = strb_q[16];
    assign p1re  = strb_q[17];
    assign m0re  = strb_q[18];
    assign m1re  = strb_q[19];
    assign blre  = strb_q[20];
    assign auc0  = strb_q[21];
    assign auc1  = strb_q[22];
    assign auf0  = strb_q[23];
    assign auf1  = strb_q[24];
    assign auv0  = strb_q[25];
    assign auv1  = strb_q[26];
    assign p0cr  = strb_q[27];
    assign p1cr  = strb_q[28];
    assign m0en  = strb_q[29];
    assign m1en  = strb_q[30];
    assign blen  = strb_q[31];
    assign p0hm  = strb_q[32];
    assign p1hm  = strb_q[33];
    assign m0hm  = strb_q[34];
    assign m1hm  = strb_q[35];
    assign blhm  = strb_q[36];
    assign p0vd  = strb_q[37];
    assign p1vd  = strb_q[38];
    assign blvd  = strb_q[39];
    assign m0pre = strb_q[40];
    assign m1pre = strb_q[41];
    assign hmove = strb_q[42];
    assign hmclr = strb_q[43];
    assign cxclr = strb_q[44];

endmodule

// File: tb/tb_tia_write_address_decodes.sv
// Self-checking bench for the TIA write-address decoder.
// Directed map/edge/reset steps followed by randomized bus cycles.
module tb_tia_write_address_decodes;

    logic        phi2;
    logic        reset;
    logic [5:0]  a;
    logic        w_bar;
    logic [44:0] s;
    logic        undef_o;
    int          checks;
    int          passed;

    tia_write_address_decodes dut (
        .phi2(phi2), .reset(reset), .a(a), .w_bar(w_bar),
        .vsyn(s[0]),   .vblk(s[1]),   .wsyn(s[2]),   .rsyn(s[3]),
        .nsz0(s[4]),   .nsz1(s[5]),   .p0ci(s[6]),   .p1ci(s[7]),
        .pfci(s[8]),   .bkci(s[9]),   .pfct(s[10]),  .p0rf(s[11]),
        .p1rf(s[12]),  .pf0(s[13]),   .pf1(s[14]),   .pf2(s[15]),
        .p0re(s[16]),  .p1re(s[17]),  .m0re(s[18]),  .m1re(s[19]),
        .blre(s[20]),  .auc0(s[21]),  .auc1(s[22]),  .auf0(s[23]),
        .auf1(s[24]),  .auv0(s[25]),  .auv1(s[26]),  .p0cr(s[27]),
        .p1cr(s[28]),  .m0en(s[29]),  .m1en(s[30]),  .blen(s[31]),
        .p0hm(s[32]),  .p1hm(s[33]),  .m0hm(s[34]),  .m1hm(s[35]),
        .blhm(s[36]),  .p0vd(s[37]),  .p1vd(s[38]),  .blvd(s[39]),
        .m0pre(s[40]), .m1pre(s[41]), .hmove(s[42]), .hmclr(s[43]),
`ifdef TIA_WDEC_UNMAPPED_FLAG_EN
        .cxclr(s[44]), .undef(undef_o)
`else
        .cxclr(s[44])
`endif
    );

`ifndef TIA_WDEC_UNMAPPED_FLAG_EN
    assign undef_o = 1'b0;
`endif

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    // Reference: register n (0..44) gets its own strobe on a write.
    function automatic logic [44:0] model(input int addr, input logic wb);
        logic [44:0] v;
        v = '0;
        if (!wb && addr >= 0 && addr <= 44) v[addr] = 1'b1;
        return v;
    endfunction

    function automatic logic model_undef(input int addr, input logic wb);
`ifdef TIA_WDEC_UNMAPPED_FLAG_EN
        return !wb && addr >= 45 && addr <= 63;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [44:0] obs, input logic [44:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // One bus cycle: drive just after rising edge, check just after falling edge.
    task automatic bus(input string tag, input int addr, input logic wb);
        @(posedge phi2);
        #1;
        a     = 6'(addr);
        w_bar = wb;
        @(negedge phi2);
        #1;
        chk(tag, s, model(addr, wb));
        chk_bit({tag, "_undef"}, undef_o, model_undef(addr, wb));
        chk_bit({tag, "_onehot"}, ($countones(s) + int'(undef_o)) <= 1, 1'b1);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset  = 1'b1;
        a      = 6'h00;
        w_bar  = 1'b0;

        // Reset holds strobes low across a falling edge with a valid write.
        #12;
        chk("reset_hold", s, '0);
        chk_bit("reset_hold_undef", undef_o, 1'b0);
        #5;
        reset = 1'b0;
        #1;
        chk("reset_release_midcycle", s, '0);
        @(negedge phi2);
        #1;
        chk("first_edge_after_release", s, model(0, 1'b0));

        // Full map sweep.
        for (int i = 0; i <= 44; i++) bus($sformatf("sweep_%02h", i), i, 1'b0);

        // Read cycle to PF0 address.
        bus("read_pf0", 13, 1'b1);
        chk_bit("read_pf0_bit", s[13], 1'b0);

        // Unmapped addresses.
        for (int i = 45; i <= 63; i++) bus($sformatf("unmapped_%02h", i), i, 1'b0);

        // Address change between edges: only the value at the falling edge counts.
        bus("vblk_write", 1, 1'b0);
        @(posedge phi2);
        #1;
        a = 6'h02;
        #2;
        chk("mid_cycle_hold_vblk", s, model(1, 1'b0));
        @(negedge phi2);
        #1;
        chk("wsyn_after_change", s, model(2, 1'b0));
        chk_bit("vblk_dropped", s[1], 1'b0);

        // Same address twice: HMCLR never drops.
        bus("hmclr_1", 43, 1'b0);
        @(posedge phi2);
        #1;
        chk_bit("hmclr_mid", s[43], 1'b1);
        @(negedge phi2);
        #1;
        chk_bit("hmclr_2", s[43], 1'b1);
        #3;
        chk_bit("hmclr_2_mid", s[43], 1'b1);

        // Asynchronous reset mid-cycle drops HMOVE at once.
        bus("hmove_write", 42, 1'b0);
        @(posedge phi2);
        #1;
        reset = 1'b1;
        #1;
        chk("hmove_async_clear", s, '0);
        @(negedge phi2);
        #1;
        chk("hmove_held_in_reset", s, '0);
        @(posedge phi2);
        #2;
        reset = 1'b0;
        #1;
        chk("hmove_after_release", s, '0);
        @(negedge phi2);
        #1;
        chk("hmove_reload", s, model(42, 1'b0));

        // Randomized bus cycles.
        for (int n = 0; n < 200; n++) begin
            int   ra;
            logic rw;
            ra = int'($urandom_range(0, 63));
            rw = ($urandom_range(0, 3) == 0);
            bus($sformatf("rand_%0d", n), ra, rw);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
